lif_spike_bank: RTL and testbench

- Downstream stage of the sparse MVM accelerator. Consumes the four 8-bit row results the accelerator streams out, one per toggle of its sending-out line.
- Integrates each result into a leaky integrate-and-fire membrane, one neuron per row, with leak, threshold, reset-to-zero and refractory hold.
- Emits a 4-bit spike vector per frame through a valid/ready handshake. The CPU side or the next layer consumes it as the next spike train.

---
 rtl/lif_spike_bank.sv | 195 +++++++++++++++++++
 tb/tb_lif_spike_bank.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lif_spike_bank.sv
// Leaky integrate-and-fire bank: four neurons fed by the toggle-strobed row stream
// of the sparse MVM accelerator, emitting one spike vector per frame over valid/ready.
module lif_spike_bank #(
  parameter int MEM_W      = 12,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_val,
  input  logic       in_toggle,
  input  logic       sync_clr,
  output logic [3:0] spikes,
  output logic       spikes_valid,
  input  logic       spikes_ready,
  output logic       overrun,
  output logic [7:0] frame_count
);

  localparam logic [31:0] THRESH_U = THRESH;
  localparam logic [7:0]  REFRAC_U = 8'(REFRAC);

  typedef enum logic {ST_EMPTY = 1'b0, ST_PENDING = 1'b1} out_state_t;

  logic             t_q_r;
  logic [1:0]       idx_r;
  logic             cap_v_r;
  logic [7:0]       cap_val_r;
  logic [1:0]       cap_idx_r;
  logic [MEM_W-1:0] v_r [4];
  logic [7:0]       refrac_r [4];
  logic [3:0]       acc_r;

  logic             accept_s;
  logic [MEM_W-1:0] v_cur_s;
  logic [7:0]       refrac_cur_s;
  logic [MEM_W:0]   sum_s;
  logic [MEM_W-1:0] sat_s;
  logic [MEM_W-1:0] v_nxt_s;
  logic [7:0]       refrac_nxt_s;
  logic             fire_s;
  logic [3:0]       fire_vec_s;
  logic [3:0]       final_acc_s;
  logic             complete_s;

  out_state_t       state_r, state_nxt_s;
  logic [3:0]       spikes_r, spikes_nxt_s;
  logic             overrun_r, overrun_nxt_s;
  logic [7:0]       frame_count_r, frame_count_nxt_s;

  assign accept_s     = (in_toggle != t_q_r);
  assign v_cur_s      = v_r[cap_idx_r];
  assign refrac_cur_s = refrac_r[cap_idx_r];
  assign complete_s   = cap_v_r && (cap_idx_r == 2'd3);

  // Leak-and-integrate for the captured neuron, saturating at the membrane maximum
  always_comb begin
    sum_s = {1'b0, v_cur_s} - {1'b0, (v_cur_s >> LEAK_SHIFT)}
          + {{(MEM_W-7){1'b0}}, cap_val_r};
    if (sum_s[MEM_W]) begin
      sat_s = {MEM_W{1'b1}};
    end else begin
      sat_s = sum_s[MEM_W-1:0];
    end
  end

  // Refractory hold, threshold test and per-frame spike accumulation
  always_comb begin
    v_nxt_s      = sat_s;
    refrac_nxt_s = refrac_cur_s;
    fire_s       = 1'b0;
    fire_vec_s   = 4'b0000;
    if (refrac_cur_s != 8'd0) begin
      refrac_nxt_s = refrac_cur_s - 8'd1;
      v_nxt_s      = {MEM_W{1'b0}};
    end else if ({{(32-MEM_W){1'b0}}, sat_s} >= THRESH_U) begin
      fire_s       = 1'b1;
      v_nxt_s      = {MEM_W{1'b0}};
      refrac_nxt_s = REFRAC_U;
    end else begin
      v_nxt_s      = sat_s;
    end
    fire_vec_s[cap_idx_r] = fire_s;
    if (cap_idx_r == 2'd0) begin
      final_acc_s = fire_vec_s;
    end else begin
      final_acc_s = acc_r | fire_vec_s;
    end
  end

  // Toggle sampling, word capture (stage 1) and membrane update (stage 2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q_r     <= 1'b0;
      idx_r     <= 2'd0;
      cap_v_r   <= 1'b0;
      cap_val_r <= 8'd0;
      cap_idx_r <= 2'd0;
      acc_r     <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        v_r[i]      <= {MEM_W{1'b0}};
        refrac_r[i] <= 8'd0;
      end
    end else begin
      t_q_r <= in_toggle;
      if (sync_clr) begin
        idx_r     <= 2'd0;
        cap_v_r   <= 1'b0;
        cap_val_r <= 8'd0;
        cap_idx_r <= 2'd0;
        acc_r     <= 4'b0000;
        for (int i = 0; i < 4; i++) begin
          v_r[i]      <= {MEM_W{1'b0}};
          refrac_r[i] <= 8'd0;
        end
      end else begin
        cap_v_r <= accept_s;
        if (accept_s) begin
          cap_val_r <= in_val;
          cap_idx_r <= idx_r;
          idx_r     <= idx_r + 2'd1;
        end
        if (cap_v_r) begin
          v_r[cap_idx_r]      <= v_nxt_s;
          refrac_r[cap_idx_r] <= refrac_nxt_s;
          acc_r               <= final_acc_s;
        end
      end
    end
  end

  // Output handshake: a completion coinciding with acceptance replaces the old vector
  always_comb begin
    state_nxt_s       = state_r;
    spikes_nxt_s      = spikes_r;
    overrun_nxt_s     = overrun_r;
    frame_count_nxt_s = frame_count_r;
    if (complete_s) begin
      frame_count_nxt_s = frame_count_r + 8'd1;
    end else begin
      frame_count_nxt_s = frame_count_r;
    end
    case (state_r)
      ST_EMPTY: begin
        if (complete_s) begin
          state_nxt_s  = ST_PENDING;
          spikes_nxt_s = final_acc_s;
        end else begin
          state_nxt_s  = ST_EMPTY;
        end
      end
      ST_PENDING: begin
        if (complete_s && spikes_ready) begin
          spikes_nxt_s  = final_acc_s;
        end else if (complete_s) begin
          spikes_nxt_s  = spikes_r | final_acc_s;
          overrun_nxt_s = 1'b1;
        end else if (spikes_ready) begin
          state_nxt_s   = ST_EMPTY;
        end else begin
          state_nxt_s   = ST_PENDING;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Output registers; frame_count survives the synchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_EMPTY;
      spikes_r      <= 4'b0000;
      overrun_r     <= 1'b0;
      frame_count_r <= 8'd0;
    end else if (sync_clr) begin
      state_r       <= ST_EMPTY;
      spikes_r      <= 4'b0000;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      spikes_r      <= spikes_nxt_s;
      overrun_r     <= overrun_nxt_s;
      frame_count_r <= frame_count_nxt_s;
    end
  end

  assign spikes       = spikes_r;
  assign spikes_valid = (state_r == ST_PENDING);
  assign overrun      = overrun_r;
  assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_lif_spike_bank.sv
// Directed self-checking bench for lif_spike_bank with hand-computed frame results.
module tb_lif_spike_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_val;
  logic       in_toggle;
  logic       sync_clr;
  logic [3:0] spikes;
  logic       spikes_valid;
  logic       spikes_ready;
  logic       overrun;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  lif_spike_bank dut (
    .clk          (clk),
    .rst          (rst),
    .in_val       (in_val),
    .in_toggle    (in_toggle),
    .sync_clr     (sync_clr),
    .spikes       (spikes),
    .spikes_valid (spikes_valid),
    .spikes_ready (spikes_ready),
    .overrun      (overrun),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] v);
    @(negedge clk);
    in_val    = v;
    in_toggle = ~in_toggle;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send_word(a);
    send_word(b);
    send_word(c);
    send_word(d);
    repeat (2) @(negedge clk);
  endtask

  task automatic accept_frame();
    @(negedge clk);
    spikes_ready = 1'b1;
    @(negedge clk);
    spikes_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_val = 8'd0; in_toggle = 1'b0; sync_clr = 1'b0; spikes_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_spikes",  32'(spikes),       32'h0);
    check_val("rst_valid",   32'(spikes_valid), 32'h0);
    check_val("rst_overrun", 32'(overrun),      32'h0);
    check_val("rst_fcount",  32'(frame_count),  32'h0);
    rst = 1'b0;

    send_frame(8'd100, 8'd0, 8'd250, 8'd255);
    check_val("f1_spikes", 32'(spikes),       32'hC);
    check_val("f1_valid",  32'(spikes_valid), 32'h1);
    check_val("f1_v0",     32'(dut.v_r[0]),   32'd100);
    check_val("f1_fcount", 32'(frame_count),  32'd1);
    check_val("f1_ovr",    32'(overrun),      32'h0);
    accept_frame();
    check_val("f1_acc_valid",  32'(spikes_valid), 32'h0);
    check_val("f1_acc_spikes", 32'(spikes),       32'hC);

    send_frame(8'd120, 8'd0, 8'd250, 8'd255);
    check_val("f2_spikes", 32'(spikes),          32'h1);
    check_val("f2_valid",  32'(spikes_valid),    32'h1);
    check_val("f2_ref2",   32'(dut.refrac_r[2]), 32'h0);
    check_val("f2_ref3",   32'(dut.refrac_r[3]), 32'h0);
    check_val("f2_v0",     32'(dut.v_r[0]),      32'h0);
    check_val("f2_fcount", 32'(frame_count),     32'd2);
    accept_frame();

    send_frame(8'd0, 8'd210, 8'd0, 8'd0);
    check_val("f3_spikes", 32'(spikes),  32'h2);
    check_val("f3_ovr",    32'(overrun), 32'h0);
    send_frame(8'd0, 8'd0, 8'd0, 8'd220);
    check_val("f4_spikes", 32'(spikes),      32'hA);
    check_val("f4_ovr",    32'(overrun),     32'h1);
    check_val("f4_fcount", 32'(frame_count), 32'd4);
    accept_frame();
    check_val("f4_acc_valid",  32'(spikes_valid), 32'h0);
    check_val("f4_acc_ovr",    32'(overrun),      32'h1);
    check_val("f4_acc_spikes", 32'(spikes),       32'hA);

    @(negedge clk); sync_clr = 1'b1;
    @(negedge clk); sync_clr = 1'b0;
    check_val("clr_ovr",    32'(overrun),     32'h0);
    check_val("clr_fcount", 32'(frame_count), 32'd4);

    send_frame(8'd0, 8'd0, 8'd0, 8'd0);
    check_val("f5_spikes", 32'(spikes),       32'h0);
    check_val("f5_valid",  32'(spikes_valid), 32'h1);
    check_val("f5_fcount", 32'(frame_count),  32'd5);

    send_word(8'd0); send_word(8'd0); send_word(8'd0); send_word(8'd210);
    @(negedge clk); spikes_ready = 1'b1;
    @(negedge clk); spikes_ready = 1'b0;
    check_val("f6_spikes", 32'(spikes),       32'h8);
    check_val("f6_valid",  32'(spikes_valid), 32'h1);
    check_val("f6_ovr",    32'(overrun),      32'h0);
    check_val("f6_fcount", 32'(frame_count),  32'd6);
    accept_frame();

    send_word(8'd1); send_word(8'd2);
    @(negedge clk); rst = 1'b1; in_toggle = 1'b0;
    #1;
    check_val("mid_rst_spikes",  32'(spikes),       32'h0);
    check_val("mid_rst_valid",   32'(spikes_valid), 32'h0);
    check_val("mid_rst_fcount",  32'(frame_count),  32'h0);
    check_val("mid_rst_overrun", 32'(overrun),      32'h0);
    @(negedge clk); rst = 1'b0;
    send_frame(8'd255, 8'd0, 8'd0, 8'd0);
    check_val("f7_spikes", 32'(spikes),       32'h1);
    check_val("f7_valid",  32'(spikes_valid), 32'h1);
    check_val("f7_fcount", 32'(frame_count),  32'd1);

    send_word(8'd150); send_word(8'd100);
    @(negedge clk); sync_clr = 1'b1;
    @(negedge clk); sync_clr = 1'b0;
    check_val("sclr_valid",  32'(spikes_valid), 32'h0);
    check_val("sclr_v0",     32'(dut.v_r[0]),   32'h0);
    check_val("sclr_fcount", 32'(frame_count),  32'd1);
    send_frame(8'd100, 8'd0, 8'd0, 8'd190);
    check_val("f8_spikes", 32'(spikes),       32'h0);
    check_val("f8_valid",  32'(spikes_valid), 32'h1);
    check_val("f8_v0",     32'(dut.v_r[0]),   32'd100);
    check_val("f8_v3",     32'(dut.v_r[3]),   32'd190);
    check_val("f8_fcount", 32'(frame_count),  32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
